// File: rtl/shift_rot_stage_pkg.sv
// Shared definitions for the rotate stage: direction encoding and width helper.
package shift_rot_stage_pkg;

  // Rotate direction encoding on in_dir.
  localparam logic ROT_LEFT  = 1'b0;
  localparam logic ROT_RIGHT = 1'b1;

  // Ceiling log2, used to size rotate-amount fields from the operand width.
  function automatic int log2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/shift_barrelfast_rleft.sv
// Combinational logarithmic barrel rotator: b = a rotated left by sh.
module shift_barrelfast_rleft
  import shift_rot_stage_pkg::*;
#(
  parameter int Bits = 64,
  localparam int ShBits = log2(Bits)
) (
  input  logic [Bits-1:0]   a,
  input  logic [ShBits-1:0] sh,
  output logic [Bits-1:0]   b
);

  // Stage s conditionally rotates left by 2**s under control of sh[s].
  for (genvar s = 0; s < ShBits; s++) begin : g_stage
    localparam int K = 1 << s;
    logic [Bits-1:0] w_in;
    logic [Bits-1:0] w_out;
    if (s == 0) begin : g_first
      assign w_in = a;
    end else begin : g_next
      assign w_in = g_stage[s-1].w_out;
    end
    assign w_out = sh[s] ? {w_in[Bits-K-1:0], w_in[Bits-1:Bits-K]} : w_in;
  end

  assign b = g_stage[ShBits-1].w_out;

endmodule

// File: rtl/skid_fifo2.sv
// Two-entry FIFO with a registered not-full flag, so the upstream ready signal
// never depends combinationally on what the consumer does this cycle.
module skid_fifo2 #(
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [Width-1:0] i_data,
  input  logic             i_pop,
  output logic [Width-1:0] o_head,
  output logic             o_notEmpty,
  output logic             o_notFull
);

  logic [Width-1:0] r_mem [2];
  logic             r_wrPtr;
  logic             r_rdPtr;
  logic [1:0]       r_count;
  logic             r_notFull;
  logic             w_doPush;
  logic             w_doPop;
  logic [1:0]       w_nextCount;

  // Qualify push/pop against current occupancy and derive the next count.
  always_comb begin
    w_doPush    = i_push && r_notFull;
    w_doPop     = i_pop && (r_count != 2'd0);
    w_nextCount = r_count + 2'(w_doPush) - 2'(w_doPop);
  end

  // Pointers, occupancy and the registered not-full flag derived from next count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr   <= 1'b0;
      r_rdPtr   <= 1'b0;
      r_count   <= 2'd0;
      r_notFull <= 1'b0;
    end else begin
      if (w_doPush) r_wrPtr <= ~r_wrPtr;
      if (w_doPop)  r_rdPtr <= ~r_rdPtr;
      r_count   <= w_nextCount;
      r_notFull <= (w_nextCount != 2'd2);
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk) begin
    if (!reset && w_doPush) r_mem[r_wrPtr] <= i_data;
  end

  assign o_head     = r_mem[r_rdPtr];
  assign o_notEmpty = (r_count != 2'd0);
  assign o_notFull  = r_notFull;

endmodule

// File: rtl/shift_rot_stage.sv
// Pipelined rotate stage: requests are normalized to a left-rotate amount,
// buffered in a two-entry skid FIFO, rotated, and registered on the output.
module shift_rot_stage
  import shift_rot_stage_pkg::*;
#(
  parameter int Bits    = 64,
  parameter int TagBits = 4,
  localparam int ShBits = log2(Bits)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [Bits-1:0]    in_a,
  input  logic [ShBits-1:0]  in_sh,
  input  logic               in_dir,
  input  logic [TagBits-1:0] in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [Bits-1:0]    out_b,
  output logic [TagBits-1:0] out_tag,
  output logic               busy
);

  typedef struct packed {
    logic [Bits-1:0]    a;
    logic [ShBits-1:0]  lsh;
    logic [TagBits-1:0] tag;
  } rot_entry_t;

  rot_entry_t          w_pushEntry;
  rot_entry_t          w_head;
  logic                w_notEmpty;
  logic                w_notFull;
  logic                w_push;
  logic                w_load;
  logic [Bits-1:0]     w_rotated;
  logic                r_outValid;
  logic [Bits-1:0]     r_outB;
  logic [TagBits-1:0]  r_outTag;

  // A right rotate by k is a left rotate by (Bits - k), modulo Bits.
  always_comb begin
    w_pushEntry.a   = in_a;
    w_pushEntry.lsh = (in_dir == ROT_RIGHT) ? ({ShBits{1'b0}} - in_sh) : in_sh;
    w_pushEntry.tag = in_tag;
  end

  assign in_ready = w_notFull && !reset;
  assign w_push   = in_valid && in_ready;
  assign w_load   = w_notEmpty && (!r_outValid || out_ready);

  skid_fifo2 #(
    .Width($bits(rot_entry_t))
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_push),
    .i_data    (w_pushEntry),
    .i_pop     (w_load),
    .o_head    (w_head),
    .o_notEmpty(w_notEmpty),
    .o_notFull (w_notFull)
  );

  shift_barrelfast_rleft #(
    .Bits(Bits)
  ) u_rot (
    .a (w_head.a),
    .sh(w_head.lsh),
    .b (w_rotated)
  );

  // Output register: load from the FIFO head when empty or being drained, hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_outValid <= 1'b0;
      r_outB     <= '0;
      r_outTag   <= '0;
    end else if (w_load) begin
      r_outValid <= 1'b1;
      r_outB     <= w_rotated;
      r_outTag   <= w_head.tag;
    end else if (out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  assign out_valid = r_outValid;
  assign out_b     = r_outB;
  assign out_tag   = r_outTag;
  assign busy      = w_notEmpty || r_outValid;

endmodule

// File: tb/tb_shift_rot_stage.sv
// Directed and randomized checks of shift_rot_stage at 8-bit and 64-bit widths.
module tb_shift_rot_stage;

  logic clk = 1'b0;
  logic reset;

  logic       inValid8, inReady8, inDir8, outValid8, outReady8, busy8;
  logic [7:0] inA8, outB8;
  logic [2:0] inSh8;
  logic [3:0] inTag8, outTag8;

  logic        inValid64, inReady64, inDir64, outValid64, outReady64, busy64;
  logic [63:0] inA64, outB64;
  logic [5:0]  inSh64;
  logic [3:0]  inTag64, outTag64;

  int nAsserts = 0;
  int nFails   = 0;

  int          reqIdx, got, sent, recvd;
  logic        accepted, seen, prevStall;
  logic [7:0]  held8;
  logic [63:0] prevB;
  logic [63:0] expB[$];
  logic [3:0]  expT[$];

  shift_rot_stage #(.Bits(8), .TagBits(4)) dut8 (
    .clk(clk), .reset(reset),
    .in_valid(inValid8), .in_ready(inReady8), .in_a(inA8), .in_sh(inSh8),
    .in_dir(inDir8), .in_tag(inTag8),
    .out_valid(outValid8), .out_ready(outReady8), .out_b(outB8), .out_tag(outTag8),
    .busy(busy8)
  );

  shift_rot_stage #(.Bits(64), .TagBits(4)) dut64 (
    .clk(clk), .reset(reset),
    .in_valid(inValid64), .in_ready(inReady64), .in_a(inA64), .in_sh(inSh64),
    .in_dir(inDir64), .in_tag(inTag64),
    .out_valid(outValid64), .out_ready(outReady64), .out_b(outB64), .out_tag(outTag64),
    .busy(busy64)
  );

  always #5 clk = ~clk;

  // Overall time limit so the bench can never hang.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [7:0] rot8(input logic [7:0] a, input int sh, input logic dir);
    logic [15:0] d;
    d = {a, a};
    if (dir) begin
      d = d >> sh;
      return d[7:0];
    end
    d = d << sh;
    return d[15:8];
  endfunction

  function automatic logic [63:0] rot64(input logic [63:0] a, input logic [5:0] sh, input logic dir);
    logic [127:0] d;
    d = {a, a};
    if (dir) begin
      d = d >> sh;
      return d[63:0];
    end
    d = d << sh;
    return d[127:64];
  endfunction

  function automatic logic [7:0] streamA(input int i);
    return 8'(i * 37 + 5);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
    nAsserts++;
    assert (observed === expected) else begin
      nFails++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", name, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [2:0] sh, input logic dir, input logic [3:0] tag);
    inValid8 = 1'b1;
    inA8     = a;
    inSh8    = sh;
    inDir8   = dir;
    inTag8   = tag;
  endtask

  task automatic runSingle(input string name, input logic [7:0] a, input logic [2:0] sh,
                           input logic dir, input logic [3:0] tag, input logic [7:0] expB);
    applyStimulus(a, sh, dir, tag);
    checkOutput({name, " in_ready"}, inReady8, 1);
    step();
    inValid8 = 1'b0;
    checkOutput({name, " valid@t+1"}, outValid8, 0);
    step();
    checkOutput({name, " valid@t+2"}, outValid8, 1);
    checkOutput({name, " out_b"}, outB8, expB);
    checkOutput({name, " out_tag"}, outTag8, tag);
    step();
    checkOutput({name, " valid drop"}, outValid8, 0);
    checkOutput({name, " idle busy"}, busy8, 0);
  endtask

  initial begin
    reset = 1'b1;
    inValid8 = 0; inA8 = 0; inSh8 = 0; inDir8 = 0; inTag8 = 0; outReady8 = 1;
    inValid64 = 0; inA64 = 0; inSh64 = 0; inDir64 = 0; inTag64 = 0; outReady64 = 0;
    step();
    step();

    // Reset state
    checkOutput("reset in_ready", inReady8, 0);
    checkOutput("reset out_valid", outValid8, 0);
    checkOutput("reset out_b", outB8, 0);
    checkOutput("reset out_tag", outTag8, 0);
    checkOutput("reset busy", busy8, 0);
    checkOutput("reset out_valid64", outValid64, 0);
    reset = 1'b0;
    step();
    checkOutput("post-reset in_ready", inReady8, 1);

    // Single requests: left, right, zero amount, wrap boundaries
    runSingle("rol1",  8'h81, 3'd1, 1'b0, 4'd3, 8'h03);
    runSingle("ror1",  8'h81, 3'd1, 1'b1, 4'd4, 8'hC0);
    runSingle("ror0",  8'hA5, 3'd0, 1'b1, 4'd5, 8'hA5);
    runSingle("ror7",  8'h01, 3'd7, 1'b1, 4'd6, 8'h02);
    runSingle("rol7",  8'h01, 3'd7, 1'b0, 4'd7, 8'h80);
    runSingle("ror4",  8'h12, 3'd4, 1'b1, 4'd8, 8'h21);
    runSingle("rol3",  8'hF0, 3'd3, 1'b0, 4'd9, 8'h87);

    // Full throughput: 16 back-to-back requests, results on consecutive cycles
    $display("[TB] throughput");
    for (int c = 0; c < 20; c++) begin
      if (c < 16) applyStimulus(streamA(c), 3'(c % 8), 1'(c % 2), 4'(c));
      else inValid8 = 1'b0;
      if (c < 16) checkOutput("thru in_ready", inReady8, 1);
      checkOutput("thru out_valid", outValid8, 64'(c >= 2 && c < 18));
      if (c >= 2 && c < 18) begin
        checkOutput("thru out_b", outB8, rot8(streamA(c - 2), (c - 2) % 8, 1'((c - 2) % 2)));
        checkOutput("thru out_tag", outTag8, 64'(c - 2));
      end
      step();
    end

    // Backpressure: absorb 3, stall, then drain in order
    $display("[TB] backpressure");
    outReady8 = 1'b0;
    reqIdx = 0;
    for (int c = 0; c < 6; c++) begin
      if (reqIdx < 5) applyStimulus(streamA(reqIdx), 3'(reqIdx % 8), 1'(reqIdx % 2), 4'(reqIdx));
      else inValid8 = 1'b0;
      accepted = inValid8 && inReady8;
      step();
      if (accepted) reqIdx++;
    end
    checkOutput("bp accepted", reqIdx, 3);
    checkOutput("bp in_ready", inReady8, 0);
    checkOutput("bp busy", busy8, 1);
    checkOutput("bp out_valid", outValid8, 1);
    checkOutput("bp out_tag", outTag8, 0);
    held8 = outB8;
    step();
    checkOutput("bp out_b hold", outB8, held8);
    checkOutput("bp out_tag hold", outTag8, 0);
    outReady8 = 1'b1;
    got = 0;
    for (int c = 0; c < 30 && got < 5; c++) begin
      if (reqIdx < 5) applyStimulus(streamA(reqIdx), 3'(reqIdx % 8), 1'(reqIdx % 2), 4'(reqIdx));
      else inValid8 = 1'b0;
      accepted = inValid8 && inReady8;
      if (c == 1) checkOutput("bp in_ready recover", inReady8, 1);
      if (outValid8 && outReady8) begin
        checkOutput("bp drain out_b", outB8, rot8(streamA(got), got % 8, 1'(got % 2)));
        checkOutput("bp drain out_tag", outTag8, 64'(got));
        got++;
      end
      step();
      if (accepted) reqIdx++;
    end
    inValid8 = 1'b0;
    checkOutput("bp results", got, 5);
    checkOutput("bp total accepted", reqIdx, 5);
    step();
    step();
    checkOutput("bp idle busy", busy8, 0);

    // Reset with three entries held and a request presented
    $display("[TB] reset mid-operation");
    outReady8 = 1'b0;
    reqIdx = 0;
    for (int c = 0; c < 6; c++) begin
      if (reqIdx < 5) applyStimulus(streamA(reqIdx), 3'(reqIdx % 8), 1'(reqIdx % 2), 4'(reqIdx));
      else inValid8 = 1'b0;
      accepted = inValid8 && inReady8;
      step();
      if (accepted) reqIdx++;
    end
    checkOutput("rst held entries", reqIdx, 3);
    checkOutput("rst busy before", busy8, 1);
    reset = 1'b1;
    applyStimulus(8'h55, 3'd1, 1'b0, 4'd9);
    checkOutput("rst in_ready during reset", inReady8, 0);
    step();
    reset = 1'b0;
    checkOutput("rst out_valid", outValid8, 0);
    checkOutput("rst busy", busy8, 0);
    applyStimulus(8'h3C, 3'd2, 1'b0, 4'd10);
    outReady8 = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (outValid8) begin
        seen = 1'b1;
        checkOutput("rst first tag", outTag8, 10);
        checkOutput("rst first out_b", outB8, 8'hF0);
      end else begin
        accepted = inValid8 && inReady8;
        step();
        if (accepted) inValid8 = 1'b0;
      end
    end
    checkOutput("rst result seen", seen, 1);
    inValid8 = 1'b0;
    step();
    step();

    // Random traffic on the 64-bit instance against a reference rotate
    $display("[TB] random 64-bit");
    sent = 0;
    recvd = 0;
    prevStall = 1'b0;
    prevB = '0;
    for (int c = 0; c < 60000 && recvd < 10000; c++) begin
      if (sent < 10000) begin
        inValid64 = ($urandom_range(0, 3) != 0);
        inA64     = {$urandom(), $urandom()};
        inSh64    = 6'($urandom_range(0, 63));
        inDir64   = 1'($urandom_range(0, 1));
        inTag64   = 4'(sent);
      end else begin
        inValid64 = 1'b0;
      end
      outReady64 = ($urandom_range(0, 3) != 0);
      if (prevStall) checkOutput("rand hold out_b", outB64, prevB);
      if (outValid64 && outReady64) begin
        if (expB.size() == 0) begin
          checkOutput("rand spurious valid", outValid64, 0);
        end else begin
          checkOutput("rand out_b", outB64, expB.pop_front());
          checkOutput("rand out_tag", outTag64, expT.pop_front());
        end
        recvd++;
      end
      if (inValid64 && inReady64) begin
        expB.push_back(rot64(inA64, inSh64, inDir64));
        expT.push_back(inTag64);
        sent++;
      end
      prevStall = outValid64 && !outReady64;
      prevB = outB64;
      step();
    end
    checkOutput("rand results", recvd, 10000);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
